// File: rtl/fir_mac_seq_ctrl.sv
// Sequencer for a pre-adder symmetric-FIR MAC: shift, walk tap pairs plus centre, flag the result.
// Optional macro FIR_MAC_CTRL_COEF_BANK_EN adds iCoeffBank and a bank MSB on oCoeffAddr.
module fir_mac_seq_ctrl #(
  parameter int TAPS = 33,
  localparam int NPAIR = (TAPS - 1) / 2,
  localparam int TAP_W = $clog2(TAPS),
  localparam int CA_W  = $clog2(NPAIR + 1)
) (
  input  logic             iClk12M,
  input  logic             iRsn,
  input  logic             iCtrlEn,
  input  logic             iSampleEn,
  input  logic             iOvrClr,
`ifdef FIR_MAC_CTRL_COEF_BANK_EN
  input  logic             iCoeffBank,
  output logic [CA_W:0]    oCoeffAddr,
`else
  output logic [CA_W-1:0]  oCoeffAddr,
`endif
  output logic             oReady,
  output logic             oShift,
  output logic [TAP_W-1:0] oHeadSel,
  output logic [TAP_W-1:0] oTailSel,
  output logic             oEnAdd,
  output logic             oEnAcc,
  output logic             oEnMul,
  output logic             oIsCenter,
  output logic             oOutValid,
  output logic             oOverrun
);

`ifdef FIR_MAC_CTRL_COEF_BANK_EN
  localparam int AW = CA_W + 1;
`else
  localparam int AW = CA_W;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MAC   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CA_W-1:0]  r_cnt;
  logic             r_ovr;
  logic             w_strobe;
  logic             w_busy;
  logic             w_accept;
  logic             w_last;
  logic [TAP_W-1:0] w_cnt_ext;
  logic [AW-1:0]    w_addr;

  assign w_strobe  = iCtrlEn & iSampleEn;
  assign w_busy    = (r_state == ST_SHIFT) | (r_state == ST_MAC);
  assign w_accept  = w_strobe & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_last    = (r_cnt >= CA_W'(NPAIR));
  assign w_cnt_ext = TAP_W'(r_cnt);

`ifdef FIR_MAC_CTRL_COEF_BANK_EN
  logic r_bank;

  // Bank is latched only when a strobe is accepted, so it stays fixed for the whole sequence
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      r_bank <= 1'b0;
    end else if (w_accept) begin
      r_bank <= iCoeffBank;
    end else begin
      r_bank <= r_bank;
    end
  end

  assign w_addr = {r_bank, r_cnt};
`else
  assign w_addr = r_cnt;
`endif

  // Sequence state and tap counter; dropping iCtrlEn aborts to IDLE from anywhere
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CA_W{1'b0}};
    end else if (!iCtrlEn) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CA_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= iSampleEn ? ST_SHIFT : ST_IDLE;
          r_cnt   <= {CA_W{1'b0}};
        end
        ST_SHIFT: begin
          r_state <= ST_MAC;
          r_cnt   <= {CA_W{1'b0}};
        end
        ST_MAC: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_cnt   <= {CA_W{1'b0}};
          end else begin
            r_state <= ST_MAC;
            r_cnt   <= r_cnt + {{(CA_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          r_state <= iSampleEn ? ST_SHIFT : ST_IDLE;
          r_cnt   <= {CA_W{1'b0}};
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= {CA_W{1'b0}};
        end
      endcase
    end
  end

  // Sticky overrun; a new overrun beats a simultaneous clear
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      r_ovr <= 1'b0;
    end else if (w_strobe & w_busy) begin
      r_ovr <= 1'b1;
    end else if (iOvrClr) begin
      r_ovr <= 1'b0;
    end else begin
      r_ovr <= r_ovr;
    end
  end

  // Moore decode of the registered state and counter
  always_comb begin
    oReady     = 1'b0;
    oShift     = 1'b0;
    oHeadSel   = {TAP_W{1'b0}};
    oTailSel   = {TAP_W{1'b0}};
    oCoeffAddr = {AW{1'b0}};
    oEnAdd     = 1'b0;
    oEnAcc     = 1'b0;
    oEnMul     = 1'b0;
    oIsCenter  = 1'b0;
    oOutValid  = 1'b0;
    case (r_state)
      ST_IDLE:  oReady = 1'b1;
      ST_SHIFT: oShift = 1'b1;
      ST_MAC: begin
        oEnMul     = 1'b1;
        oHeadSel   = w_cnt_ext;
        oCoeffAddr = w_addr;
        oEnAdd     = (r_cnt == {CA_W{1'b0}});
        oEnAcc     = (r_cnt != {CA_W{1'b0}});
        if (w_last) begin
          oTailSel  = TAP_W'(NPAIR);
          oIsCenter = 1'b1;
        end else begin
          oTailSel  = TAP_W'(TAPS - 1) - w_cnt_ext;
          oIsCenter = 1'b0;
        end
      end
      ST_DONE: begin
        oReady    = 1'b1;
        oOutValid = 1'b1;
      end
      default: oReady = 1'b0;
    endcase
  end

  assign oOverrun = r_ovr;

endmodule

// File: tb/tb_fir_mac_seq_ctrl.sv
// Bench for fir_mac_seq_ctrl: timeline reference model plus a delay-chain/MAC datapath model.
module tb_fir_mac_seq_ctrl;
  localparam int TAPS  = 33;
  localparam int NPAIR = 16;
  localparam int TAP_W = 6;
  localparam int CA_W  = 5;
`ifdef FIR_MAC_CTRL_COEF_BANK_EN
  localparam int AW = CA_W + 1;
`else
  localparam int AW = CA_W;
`endif
  localparam int VW = 8 + 2 * TAP_W + AW;

  logic clk = 1'b0;
  logic rsn = 1'b0;
  logic ctrl_en = 1'b0, sample_en = 1'b0, ovr_clr = 1'b0, coeff_bank = 1'b0;
  logic o_ready, o_shift, o_add, o_acc, o_mul, o_ctr, o_valid, o_ovr;
  logic [TAP_W-1:0] o_head, o_tail;
  logic [AW-1:0] o_addr;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fir_mac_seq_ctrl #(.TAPS(TAPS)) dut (
    .iClk12M(clk), .iRsn(rsn), .iCtrlEn(ctrl_en), .iSampleEn(sample_en), .iOvrClr(ovr_clr),
`ifdef FIR_MAC_CTRL_COEF_BANK_EN
    .iCoeffBank(coeff_bank),
`endif
    .oCoeffAddr(o_addr), .oReady(o_ready), .oShift(o_shift), .oHeadSel(o_head),
    .oTailSel(o_tail), .oEnAdd(o_add), .oEnAcc(o_acc), .oEnMul(o_mul),
    .oIsCenter(o_ctr), .oOutValid(o_valid), .oOverrun(o_ovr)
  );

  // Reference model: position on the sequence timeline, counted in edges since acceptance
  int t_edge = 0;
  int m_start = -1000;
  bit m_ovr = 1'b0;
  bit m_bank = 1'b0;
  int hist[$];
  longint m_y = 0;
  int cur_sample = 0;

  // Datapath model driven by the DUT controls
  int dl [0:TAPS-1] = '{default: 0};
  int coef [0:(1<<AW)-1] = '{default: 0};
  longint acc = 0;

  function automatic longint mac_prod();
    if (o_ctr) return longint'(dl[o_head]) * coef[o_addr];
    else       return longint'(dl[o_head] + dl[o_tail]) * coef[o_addr];
  endfunction

  always @(posedge clk) begin
    if (o_shift) begin
      for (int i = TAPS - 1; i > 0; i--) dl[i] <= dl[i-1];
      dl[0] <= cur_sample;
    end
    if (o_mul && o_add) acc <= mac_prod();
    else if (o_mul && o_acc) acc <= acc + mac_prod();
  end

  function automatic logic [VW-1:0] exp_vec(int d, bit ovr, bit bank);
    logic rdy, sh, add, ac, mul, ctr, vld;
    logic [TAP_W-1:0] h, t;
    logic [AW-1:0] a;
    int c;
    sh = (d == 1);
    rdy = !(d >= 1 && d <= NPAIR + 2);
    vld = (d == NPAIR + 3);
    h = '0; t = '0; a = '0; add = 0; ac = 0; mul = 0; ctr = 0;
    if (d >= 2 && d <= NPAIR + 2) begin
      c = d - 2;
      mul = 1;
      h = TAP_W'(c);
      t = (c == NPAIR) ? TAP_W'(NPAIR) : TAP_W'(TAPS - 1 - c);
      a = AW'(c + (bank ? (1 << CA_W) : 0));
      add = (c == 0);
      ac = (c != 0);
      ctr = (c == NPAIR);
    end
    return {rdy, sh, h, t, a, add, ac, mul, ctr, vld, ovr};
  endfunction

  function automatic logic [VW-1:0] cur_exp();
    return exp_vec(t_edge - m_start, m_ovr, m_bank);
  endfunction

  function automatic logic [VW-1:0] get_obs();
    return {o_ready, o_shift, o_head, o_tail, o_addr, o_add, o_acc, o_mul, o_ctr, o_valid, o_ovr};
  endfunction

  task automatic tick();
    int d;
    bit busy;
    @(posedge clk);
    d = t_edge - m_start;
    busy = (d >= 1 && d <= NPAIR + 2);
    if (ctrl_en && sample_en && busy) m_ovr = 1'b1;
    else if (ovr_clr) m_ovr = 1'b0;
    if (!ctrl_en) begin
      m_start = t_edge - 1000;
    end else if (sample_en && !busy) begin
      m_start = t_edge;
      m_bank = coeff_bank;
      hist.push_front(cur_sample);
      if (hist.size() > TAPS) void'(hist.pop_back());
      m_y = 0;
      for (int k = 0; k < hist.size(); k++)
        m_y += longint'(hist[k]) * coef[(k < TAPS - 1 - k) ? k : TAPS - 1 - k];
    end
    t_edge++;
    #1;
  endtask

  task automatic test_reset();
    logic [VW-1:0] rst_vec;
    rst_vec = '0;
    rst_vec[VW-1] = 1'b1;
    ctrl_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (get_obs() !== rst_vec) begin
      n_fail++;
      $display("FAIL reset_vec got=%h want=%h", get_obs(), rst_vec);
    end
    @(negedge clk) rsn = 1'b1;
    tick();
    n_cmp++;
    if (get_obs() !== cur_exp()) begin
      n_fail++;
      $display("FAIL reset_idle got=%h want=%h", get_obs(), cur_exp());
    end
  endtask

  task automatic test_single();
    int vcyc;
    vcyc = -1;
    cur_sample = int'($urandom_range(0, 255));
    sample_en = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      sample_en = 1'b0;
      n_cmp++;
      if (get_obs() !== cur_exp()) begin
        n_fail++;
        $display("FAIL single cyc%0d got=%h want=%h", i, get_obs(), cur_exp());
      end
      if (o_valid && vcyc < 0) vcyc = i;
    end
    n_cmp++;
    if (vcyc !== 19) begin
      n_fail++;
      $display("FAIL single_latency got=%0d want=19", vcyc);
    end
  endtask

  task automatic test_stream(input bit ones, input int nstrobe);
    int nval, gap;
    nval = 0;
    for (int i = 0; i <= NPAIR; i++) coef[i] = ones ? 1 : int'($urandom_range(0, 255));
    for (int s = 0; s < nstrobe; s++) begin
      gap = ones ? 19 : int'($urandom_range(19, 24));
      cur_sample = ones ? 1 : int'($urandom_range(0, 255));
      sample_en = 1'b1;
      for (int c = 0; c < gap; c++) begin
        ovr_clr = ones ? 1'b0 : ($urandom_range(0, 3) == 0);
        tick();
        sample_en = 1'b0;
        n_cmp++;
        if (get_obs() !== cur_exp()) begin
          n_fail++;
          $display("FAIL stream s%0d c%0d got=%h want=%h", s, c, get_obs(), cur_exp());
        end
        if (o_valid) begin
          nval++;
          n_cmp++;
          if (acc !== m_y) begin
            n_fail++;
            $display("FAIL stream_mac s%0d got=%0d want=%0d", s, acc, m_y);
          end
        end
      end
    end
    ovr_clr = 1'b0;
    n_cmp++;
    if (nval !== nstrobe) begin
      n_fail++;
      $display("FAIL stream_count got=%0d want=%0d", nval, nstrobe);
    end
    if (ones) begin
      n_cmp++;
      if (acc !== 64'sd33) begin
        n_fail++;
        $display("FAIL ones_sum got=%0d want=33", acc);
      end
    end
  endtask

  task automatic test_overrun();
    int nval;
    nval = 0;
    cur_sample = int'($urandom_range(0, 255));
    sample_en = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      sample_en = (c == 5) || (c == 10);
      ovr_clr = (c == 10);
      n_cmp++;
      if (get_obs() !== cur_exp()) begin
        n_fail++;
        $display("FAIL overrun c%0d got=%h want=%h", c, get_obs(), cur_exp());
      end
      if (o_valid) nval++;
    end
    n_cmp++;
    if (nval !== 1 || o_ovr !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky got=%0d/%b want=1/1", nval, o_ovr);
    end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    n_cmp++;
    if (o_ovr !== 1'b0 || get_obs() !== cur_exp()) begin
      n_fail++;
      $display("FAIL overrun_clear got=%b want=0", o_ovr);
    end
  endtask

  task automatic test_abort();
    int nval;
    nval = 0;
    sample_en = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      sample_en = 1'b0;
    end
    n_cmp++;
    if (o_head !== 6'd8 || get_obs() !== cur_exp()) begin
      n_fail++;
      $display("FAIL abort_pre got=%h want=%h", get_obs(), cur_exp());
    end
    ctrl_en = 1'b0;
    sample_en = 1'b1;
    tick();
    ctrl_en = 1'b1;
    sample_en = 1'b0;
    n_cmp++;
    if ({o_ready, o_mul, o_add, o_acc, o_shift} !== 5'b10000 || get_obs() !== cur_exp()) begin
      n_fail++;
      $display("FAIL abort_idle got=%h want=%h", get_obs(), cur_exp());
    end
    for (int c = 0; c < 15; c++) begin
      tick();
      if (o_valid) nval++;
    end
    n_cmp++;
    if (nval !== 0) begin
      n_fail++;
      $display("FAIL abort_novalid got=%0d want=0", nval);
    end
    test_single();
  endtask

  task automatic test_async_reset();
    logic [VW-1:0] rst_vec;
    int nval;
    rst_vec = '0;
    rst_vec[VW-1] = 1'b1;
    nval = 0;
    sample_en = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      sample_en = 1'b0;
    end
    #2 rsn = 1'b0;
    #1;
    m_start = t_edge - 1000;
    m_ovr = 1'b0;
    n_cmp++;
    if (get_obs() !== rst_vec) begin
      n_fail++;
      $display("FAIL async_reset got=%h want=%h", get_obs(), rst_vec);
    end
    @(negedge clk) rsn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (o_valid) nval++;
    end
    n_cmp++;
    if (nval !== 0) begin
      n_fail++;
      $display("FAIL async_novalid got=%0d want=0", nval);
    end
    test_single();
  endtask

`ifdef FIR_MAC_CTRL_COEF_BANK_EN
  task automatic test_bank();
    coeff_bank = 1'b1;
    sample_en = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      sample_en = 1'b0;
      coeff_bank = ~coeff_bank;
      n_cmp++;
      if (get_obs() !== cur_exp() || (o_mul && (o_addr < 6'd32 || o_addr > 6'd48))) begin
        n_fail++;
        $display("FAIL bank c%0d got=%h want=%h", c, get_obs(), cur_exp());
      end
    end
    coeff_bank = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream(1'b1, 34);
    test_stream(1'b0, 8);
    test_overrun();
    test_abort();
    test_async_reset();
`ifdef FIR_MAC_CTRL_COEF_BANK_EN
    test_bank();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
